// File: rtl/als_sample_scheduler.sv
// Sample scheduler for the ambient-light-sensor SPI reader: requests frames
// periodically or on demand, extracts the light code, averages it and keeps a dark flag.
module als_sample_scheduler #(
  parameter int PERIOD_CYCLES  = 50000,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DARK_LO        = 20,
  parameter int DARK_HI        = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        trigger,
  input  logic        err_clr,
  input  logic        als_ready,
  input  logic [15:0] als_data,
  output logic        als_initiate,
  output logic        busy,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic [7:0]  avg,
  output logic        avg_valid,
  output logic        dark,
  output logic        timeout_err
);

  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST     = CW'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]    DARK_LO_C    = 8'(DARK_LO);
  localparam logic [7:0]    DARK_HI_C    = 8'(DARK_HI);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACCEPT, S_XFER} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_period_cnt;
  logic          r_pending;
  logic [TW-1:0] r_to_cnt;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;

  logic          w_wrap;
  logic          w_req;
  logic          w_fire;
  logic          w_capture;
  logic          w_timeout;
  logic          w_to_run;
  logic [AW-1:0] w_acc_sum;
  logic [7:0]    w_avg_nxt;
  logic          w_unused;

  assign w_wrap    = enable && (r_period_cnt == PERIOD_LAST);
  assign w_req     = trigger | w_wrap;
  assign busy      = (r_state != S_IDLE);
  assign w_acc_sum = r_acc + AW'(sample);
  assign w_avg_nxt = w_acc_sum[AVG_LOG2 +: 8];
  // Only the light-code field of the frame is meaningful.
  assign w_unused  = ^{als_data[15:13], als_data[4:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_to_run    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (als_ready) begin
          w_fire      = 1'b1;
          w_state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (r_to_cnt == TIMEOUT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_run = 1'b1;
          if (!als_ready) w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        // A frame that completes on the last allowed cycle is still accepted.
        if (als_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == TIMEOUT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_run = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period_cnt <= '0;
      r_pending    <= 1'b0;
      r_to_cnt     <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      als_initiate <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      avg          <= '0;
      avg_valid    <= 1'b0;
      dark         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (!enable || w_wrap) r_period_cnt <= '0;
      else                   r_period_cnt <= r_period_cnt + PW'(1);

      // A request landing on the initiate cycle survives as the next pending one.
      if (w_fire)     r_pending <= w_req;
      else if (w_req) r_pending <= 1'b1;

      als_initiate <= w_fire;

      if (w_fire)        r_to_cnt <= '0;
      else if (w_to_run) r_to_cnt <= r_to_cnt + TW'(1);

      sample_valid <= w_capture;
      if (w_capture) sample <= als_data[12:5];

      if (w_timeout)    timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      avg_valid <= 1'b0;
      if (sample_valid) begin
        if (r_cnt == CNT_LAST) begin
          r_acc     <= '0;
          r_cnt     <= '0;
          avg       <= w_avg_nxt;
          avg_valid <= 1'b1;
          if (w_avg_nxt < DARK_LO_C)      dark <= 1'b1;
          else if (w_avg_nxt > DARK_HI_C) dark <= 1'b0;
        end else begin
          r_acc <= w_acc_sum;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/als_sample_scheduler.md
Name: als_sample_scheduler

Overview:
- Sequences the ambient-light-sensor SPI reader.
- Issues a one-cycle `als_initiate` either periodically or on demand, waits for the reader's `ready` handshake, and extracts the 8-bit light code from the 16-bit frame.
- Averages 2^AVG_LOG2 samples and derives a hysteretic `dark` flag.
- Sits between the ALS reader and the application logic (display/LED control); it is the only block that drives the reader's `initiate`.

Parameters:
- PERIOD_CYCLES, 50000: clk cycles between automatic sample requests (1 ms at 50 MHz); legal range 2..2^20.
- AVG_LOG2, 2: log2 of samples per average; legal range 0..4.
- TIMEOUT_CYCLES, 4096: maximum clk cycles from `als_initiate` to frame completion before abort.
- DARK_LO, 20: `dark` sets when the average is < DARK_LO.
- DARK_HI, 30: `dark` clears when the average is > DARK_HI; DARK_HI >= DARK_LO is required.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  enables periodic sampling
- trigger  in  1  one-shot sample request (any cycle)
- err_clr  in  1  clears sticky `timeout_err`
- als_ready  in  1  reader idle/ready
- als_data  in  16  reader shift register
- als_initiate  out  1  start pulse to reader
- busy  out  1  transaction in flight
- sample  out  8  last valid light code
- sample_valid  out  1  one-cycle strobe
- avg  out  8  last average
- avg_valid  out  1  one-cycle strobe
- dark  out  1  hysteretic dark flag
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync release via clk): all outputs 0; state IDLE; period counter, pending, accumulator, sample count and timeout counter all 0.
- Period counter:
  - Counts while `enable`=1; held at 0 while `enable`=0.
  - At PERIOD_CYCLES-1 it wraps to 0 and sets `pending`.
- `trigger`=1 sets `pending` regardless of `enable`.
- Requests arriving while `pending` is set or `busy` is high merge into the single pending bit; no queueing beyond one.
- FSM:
  - IDLE: if `pending` -> ARM.
  - ARM: wait for `als_ready`=1; then assert `als_initiate` for exactly one cycle, clear `pending` (unless a new request arrives that same cycle, which keeps it set), clear the timeout counter -> ACCEPT.
  - ACCEPT: wait for `als_ready`=0 -> XFER.
  - XFER: on the first cycle with `als_ready`=1, capture `sample` <= `als_data[12:5]`, pulse `sample_valid` for one cycle -> IDLE.
- `busy`=1 in ARM, ACCEPT and XFER.
- Latency: `als_initiate` occurs 2 cycles after `pending` sets when the reader is already ready.
- Timeout:
  - Counter increments each cycle in ACCEPT/XFER.
  - On reaching TIMEOUT_CYCLES-1: set `timeout_err`, discard the sample (no `sample_valid`, not accumulated) -> IDLE.
  - `timeout_err` stays set until `err_clr`; if a timeout and `err_clr` occur in the same cycle, set wins.
- Averaging:
  - Each `sample_valid` adds `sample` into a (8+AVG_LOG2)-bit accumulator and increments the count.
  - When the count reaches 2^AVG_LOG2: `avg` <= accumulator >> AVG_LOG2 (truncating), pulse `avg_valid` the following cycle, zero accumulator and count.
  - AVG_LOG2=0: `avg` mirrors every sample.
- `dark` is updated only on the `avg_valid` cycle, using the new `avg`:
  - `avg` < DARK_LO -> 1
  - `avg` > DARK_HI -> 0
  - otherwise hold.
- `enable` falling mid-transaction: the in-flight transaction completes normally; an already-set `pending` is still served.
- Reset mid-transaction: immediate return to IDLE with `als_initiate`=0. The reader is reset by the same net and needs no other recovery.
- `als_initiate` is never asserted while `als_ready`=0.

Test Plan (PERIOD_CYCLES=100, AVG_LOG2=2, TIMEOUT_CYCLES=64, reader BFM):
- Periodic sampling: `enable`=1, BFM returns frame 16'h0A60 -> `als_initiate` every 100 cycles; `sample`=8'h53 with `sample_valid`; after the 4th sample `avg`=8'h53 and `avg_valid` pulses once.
- Averaging truncation: samples 10, 11, 12, 14 -> `avg`=11; then samples 40,40,40,40 -> `avg`=40.
- Dark hysteresis, DARK_LO=20, DARK_HI=30: avg sequence 25, 15, 25, 31, 25 -> `dark` = 0, 1, 1, 0, 0.
- Merging: `enable`=0, `trigger` pulsed 3 times during one 40-cycle transaction -> exactly one extra transaction follows; `als_initiate` is never asserted while `als_ready`=0.
- Timeout: BFM holds `ready` low forever after `initiate` -> `timeout_err`=1 at 64 cycles, no `sample_valid`, accumulator count unchanged; `err_clr` -> `timeout_err`=0.
- Async reset asserted in XFER -> all outputs 0 without a clk edge; after release with `enable`=1, the next `als_initiate` occurs 100+2 cycles later.
